// File: rtl/sie_pkg.sv
`default_nettype none
// ============================================================================
// sie_pkg : phase codes and envelope arithmetic for the SIE phase sequencer
// Rev 1.0
// ============================================================================
package sie_pkg;

  localparam logic [2:0] PH_IDLE        = 3'd1;
  localparam logic [2:0] PH_COHERENCE   = 3'd2;
  localparam logic [2:0] PH_IGNITION    = 3'd3;
  localparam logic [2:0] PH_PLATEAU     = 3'd4;
  localparam logic [2:0] PH_PROPAGATION = 3'd5;
  localparam logic [2:0] PH_DECAY       = 3'd6;
  localparam logic [2:0] PH_REFRACTORY  = 3'd7;

  localparam logic signed [31:0] ONE_Q14 = 32'sd16384;

  // Encoding doubles as the externally visible phase code.
  typedef enum logic [2:0] {
    S_IDLE        = PH_IDLE,
    S_COHERENCE   = PH_COHERENCE,
    S_IGNITION    = PH_IGNITION,
    S_PLATEAU     = PH_PLATEAU,
    S_PROPAGATION = PH_PROPAGATION,
    S_DECAY       = PH_DECAY,
    S_REFRACTORY  = PH_REFRACTORY
  } sie_phase_e;

  function automatic logic signed [31:0] env_sat_add(
    input logic signed [31:0] env,
    input logic signed [31:0] delta,
    input logic signed [31:0] limit
  );
    logic signed [31:0] sum;
    sum = env + delta;
    if (sum > limit) begin
      return limit;
    end else if (sum < 32'sd0) begin
      return 32'sd0;
    end
    return sum;
  endfunction

  // A zero duration still occupies one tick.
  function automatic logic [15:0] dur_to_load(input logic [15:0] dur);
    return (dur == 16'd0) ? 16'd0 : (dur - 16'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sie_phase_timer.sv
`default_nettype none
// ============================================================================
// sie_phase_timer : 16-bit loadable down-counter with zero flag, clk_en gated
// Rev 1.0
// ============================================================================
module sie_phase_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count,
  output logic        zero
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clk_en) begin
      if (load) begin
        count_d = load_value;
      end else if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 16'd0);

endmodule
`default_nettype wire

// File: rtl/sie_phase_sequencer.sv
`default_nettype none
// ============================================================================
// sie_phase_sequencer : runs one SIE event through phases 2-6 plus refractory
// Rev 1.0
// ============================================================================
module sie_phase_sequencer
  import sie_pkg::*;
#(
  parameter int                      WIDTH         = 18,
  parameter int                      FRAC          = 14,
  parameter logic signed [WIDTH-1:0] ENV_STEP_UP   = 18'sd16,
  parameter logic signed [WIDTH-1:0] ENV_STEP_DOWN = 18'sd8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    trigger,
  input  logic                    abort,
  input  logic [15:0]             sie_phase2_dur,
  input  logic [15:0]             sie_phase3_dur,
  input  logic [15:0]             sie_phase4_dur,
  input  logic [15:0]             sie_phase5_dur,
  input  logic [15:0]             sie_phase6_dur,
  input  logic [15:0]             sie_refractory,
  output logic [2:0]              sie_phase,
  output logic                    sie_active,
  output logic                    in_refractory,
  output logic                    ignition_pulse,
  output logic                    trigger_rejected,
  output logic [15:0]             phase_timer,
  output logic signed [WIDTH-1:0] sie_envelope
);

  localparam logic signed [31:0] UNITY = 32'sd1 <<< FRAC;

  sie_phase_e             phase_q, phase_d;
  logic [5:0][15:0]       snap_q, snap_d;
  logic signed [WIDTH-1:0] env_q, env_d;
  logic                   ign_pulse_q, ign_pulse_d;
  logic                   rejected_q, rejected_d;

  logic [5:0][15:0]       dur_in;
  logic [15:0]            sel_dur;
  logic                   timer_load;
  logic                   timer_zero;
  logic [15:0]            timer_count;

  assign dur_in = {sie_refractory, sie_phase6_dur, sie_phase5_dur,
                   sie_phase4_dur, sie_phase3_dur, sie_phase2_dur};

  always_comb begin
    phase_d = phase_q;
    snap_d  = snap_q;
    if (clk_en) begin
      case (phase_q)
        S_IDLE: begin
          if (trigger) begin
            phase_d = S_COHERENCE;
            snap_d  = dur_in;
          end
        end
        S_COHERENCE, S_IGNITION, S_PLATEAU, S_PROPAGATION, S_DECAY: begin
          if (abort) begin
            phase_d = S_REFRACTORY;
          end else if (timer_zero) begin
            phase_d = sie_phase_e'(phase_q + 3'd1);
          end
        end
        S_REFRACTORY: begin
          if (timer_zero) begin
            phase_d = S_IDLE;
          end
        end
        default: phase_d = S_IDLE;
      endcase
    end
  end

  // snap_d, not snap_q, so the entry into COHERENCE sees the freshly latched value.
  always_comb begin
    sel_dur = 16'd0;
    case (phase_d)
      S_COHERENCE:   sel_dur = snap_d[0];
      S_IGNITION:    sel_dur = snap_d[1];
      S_PLATEAU:     sel_dur = snap_d[2];
      S_PROPAGATION: sel_dur = snap_d[3];
      S_DECAY:       sel_dur = snap_d[4];
      S_REFRACTORY:  sel_dur = snap_d[5];
      default:       sel_dur = 16'd0;
    endcase
  end

  assign timer_load = (phase_d != phase_q);

  sie_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .load       (timer_load),
    .load_value (dur_to_load(sel_dur)),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  // Envelope follows the phase being entered or held on this tick.
  always_comb begin
    env_d       = env_q;
    ign_pulse_d = 1'b0;
    rejected_d  = 1'b0;
    if (clk_en) begin
      case (phase_d)
        S_IGNITION:
          env_d = WIDTH'(env_sat_add(32'(env_q), 32'(ENV_STEP_UP), UNITY));
        S_DECAY:
          env_d = WIDTH'(env_sat_add(32'(env_q), -32'(ENV_STEP_DOWN), UNITY));
        S_PLATEAU, S_PROPAGATION:
          env_d = env_q;
        default:
          env_d = '0;
      endcase
      ign_pulse_d = (phase_d == S_IGNITION) && (phase_q != S_IGNITION);
      rejected_d  = trigger && (phase_q != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= S_IDLE;
      snap_q      <= '0;
      env_q       <= '0;
      ign_pulse_q <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      snap_q      <= snap_d;
      env_q       <= env_d;
      ign_pulse_q <= ign_pulse_d;
      rejected_q  <= rejected_d;
    end
  end

  assign sie_phase        = phase_q;
  assign sie_active       = (phase_q >= S_COHERENCE) && (phase_q <= S_DECAY);
  assign in_refractory    = (phase_q == S_REFRACTORY);
  assign ignition_pulse   = ign_pulse_q;
  assign trigger_rejected = rejected_q;
  assign phase_timer      = timer_count;
  assign sie_envelope     = env_q;

endmodule
`default_nettype wire

// File: tb/tb_sie_phase_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sie_phase_sequencer : directed bench with a tick-level reference model
// Rev 1.0
// ============================================================================
module tb_sie_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        trigger = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] d2 = '0, d3 = '0, d4 = '0, d5 = '0, d6 = '0, drefr = '0;

  logic [2:0]         a_phase, b_phase;
  logic               a_active, b_active, a_refr, b_refr;
  logic               a_ign, b_ign, a_rej, b_rej;
  logic [15:0]        a_timer, b_timer;
  logic signed [17:0] a_env, b_env;

  int tests = 0;
  int fails = 0;
  int ign_cnt = 0;
  int rej_cnt = 0;

  sie_phase_sequencer u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .trigger(trigger), .abort(abort),
    .sie_phase2_dur(d2), .sie_phase3_dur(d3), .sie_phase4_dur(d4),
    .sie_phase5_dur(d5), .sie_phase6_dur(d6), .sie_refractory(drefr),
    .sie_phase(a_phase), .sie_active(a_active), .in_refractory(a_refr),
    .ignition_pulse(a_ign), .trigger_rejected(a_rej),
    .phase_timer(a_timer), .sie_envelope(a_env)
  );

  sie_phase_sequencer #(.ENV_STEP_UP(18'sd8192)) u_dut_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en), .trigger(trigger), .abort(abort),
    .sie_phase2_dur(d2), .sie_phase3_dur(d3), .sie_phase4_dur(d4),
    .sie_phase5_dur(d5), .sie_phase6_dur(d6), .sie_refractory(drefr),
    .sie_phase(b_phase), .sie_active(b_active), .in_refractory(b_refr),
    .ignition_pulse(b_ign), .trigger_rejected(b_rej),
    .phase_timer(b_timer), .sie_envelope(b_env)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the active edge.
  logic s_rst = 1'b1, s_en = 1'b0, s_trig = 1'b0, s_abort = 1'b0;
  int   s_dur [8];
  always @(posedge clk) begin
    s_rst    <= rst;
    s_en     <= clk_en;
    s_trig   <= trigger;
    s_abort  <= abort;
    s_dur[2] <= int'(d2);
    s_dur[3] <= int'(d3);
    s_dur[4] <= int'(d4);
    s_dur[5] <= int'(d5);
    s_dur[6] <= int'(d6);
    s_dur[7] <= int'(drefr);
    if (a_ign) ign_cnt <= ign_cnt + 1;
    if (a_rej) rej_cnt <= rej_cnt + 1;
  end

  // Reference: phase number, ticks left in phase, two envelopes.
  int m_phase = 1, m_left = 0, m_env_a = 0, m_env_b = 0;
  int m_dur [8];
  int m_ign = 0, m_rej = 0;

  task automatic m_enter(input int p);
    m_phase = p;
    if (p == 1) m_left = 0;
    else        m_left = (m_dur[p] == 0) ? 1 : m_dur[p];
    if (p == 3) m_ign = 1;
  endtask

  task automatic m_step();
    m_ign = 0;
    m_rej = (s_trig && m_phase != 1) ? 1 : 0;
    if (m_phase == 1) begin
      if (s_trig) begin
        m_dur = s_dur;
        m_enter(2);
      end
    end else if (m_phase <= 6 && s_abort) begin
      m_enter(7);
    end else begin
      m_left--;
      if (m_left == 0) m_enter(m_phase == 7 ? 1 : m_phase + 1);
    end
    case (m_phase)
      3: begin
        m_env_a = (m_env_a + 16 > 16384) ? 16384 : m_env_a + 16;
        m_env_b = (m_env_b + 8192 > 16384) ? 16384 : m_env_b + 8192;
      end
      6: begin
        m_env_a = (m_env_a < 8) ? 0 : m_env_a - 8;
        m_env_b = (m_env_b < 8) ? 0 : m_env_b - 8;
      end
      4, 5: ;
      default: begin
        m_env_a = 0;
        m_env_b = 0;
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst || s_rst) begin
        m_phase = 1; m_left = 0; m_env_a = 0; m_env_b = 0; m_ign = 0; m_rej = 0;
        foreach (m_dur[k]) m_dur[k] = 0;
      end else if (s_en) begin
        m_step();
      end else begin
        m_ign = 0;
        m_rej = 0;
      end
      check("phase",    int'(a_phase),  m_phase);
      check("active",   int'(a_active), (m_phase >= 2 && m_phase <= 6) ? 1 : 0);
      check("refr",     int'(a_refr),   (m_phase == 7) ? 1 : 0);
      check("ign",      int'(a_ign),    m_ign);
      check("rej",      int'(a_rej),    m_rej);
      check("timer",    int'(a_timer),  (m_phase == 1) ? 0 : m_left - 1);
      check("env",      int'(a_env),    m_env_a);
      check("b_phase",  int'(b_phase),  m_phase);
      check("b_active", int'(b_active), (m_phase >= 2 && m_phase <= 6) ? 1 : 0);
      check("b_refr",   int'(b_refr),   (m_phase == 7) ? 1 : 0);
      check("b_ign",    int'(b_ign),    m_ign);
      check("b_rej",    int'(b_rej),    m_rej);
      check("b_timer",  int'(b_timer),  (m_phase == 1) ? 0 : m_left - 1);
      check("b_env",    int'(b_env),    m_env_b);
    end
  end

  task automatic set_durs(input int p2, p3, p4, p5, p6, pr);
    d2 = 16'(p2); d3 = 16'(p3); d4 = 16'(p4);
    d5 = 16'(p5); d6 = 16'(p6); drefr = 16'(pr);
  endtask

  // One clk_en tick every 4 clocks; entered and left on a falling edge.
  task automatic tick();
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int STD_PH  [20] = '{2,2,2,3,3,4,4,5,5,5,5,6,6,6,7,7,7,7,7,1};
  int STD_ENV [20] = '{0,0,0,16,32,32,32,32,32,32,32,24,16,8,0,0,0,0,0,0};
  int ZERO_PH [7]  = '{2,3,4,5,6,7,1};

  task automatic run_std(input bit change_durs);
    int ign0;
    ign0 = ign_cnt;
    set_durs(3, 2, 2, 4, 3, 5);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    if (change_durs) set_durs(100, 100, 100, 100, 100, 100);
    check("tl_phase", int'(a_phase), STD_PH[0]);
    check("tl_env", int'(a_env), STD_ENV[0]);
    for (int i = 1; i < 20; i++) begin
      tick();
      check("tl_phase", int'(a_phase), STD_PH[i]);
      check("tl_env", int'(a_env), STD_ENV[i]);
    end
    check("tl_ign_count", ign_cnt - ign0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0;
    @(negedge clk);
    check("rst_phase", int'(a_phase), 1);
    check("rst_env", int'(a_env), 0);
    check("rst_timer", int'(a_timer), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Idle, no trigger.
    repeat (20) tick();
    check("idle_phase", int'(a_phase), 1);
    check("idle_env", int'(a_env), 0);
    check("idle_ign", ign_cnt, 0);
    check("idle_rej", rej_cnt, 0);

    run_std(1'b0);
    run_std(1'b1);

    // Envelope saturation on the big-step instance.
    set_durs(1, 4, 1, 1, 1, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    check("sat_env_b1", int'(b_env), 8192);
    check("sat_env_a1", int'(a_env), 16);
    tick();
    check("sat_env_b2", int'(b_env), 16384);
    tick();
    check("sat_env_b3", int'(b_env), 16384);
    tick();
    check("sat_env_b4", int'(b_env), 16384);
    check("sat_env_a4", int'(a_env), 64);
    repeat (5) tick();
    check("sat_end_phase", int'(a_phase), 1);

    // Trigger held through a whole event.
    set_durs(1, 1, 1, 1, 1, 1);
    r0 = rej_cnt;
    trigger = 1'b1;
    tick();
    repeat (6) tick();
    check("hold_rej_count", rej_cnt - r0, 6);
    check("hold_phase_idle", int'(a_phase), 1);
    tick();
    check("hold_restart", int'(a_phase), 2);
    check("hold_rej_after", rej_cnt - r0, 6);
    trigger = 1'b0;
    repeat (6) tick();
    check("hold_end_phase", int'(a_phase), 1);

    // Abort in PROPAGATION with two ticks still to go.
    set_durs(1, 1, 1, 4, 1, 3);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    set_durs(9, 9, 9, 9, 9, 9);
    repeat (4) tick();
    check("ab_pre_phase", int'(a_phase), 5);
    check("ab_pre_timer", int'(a_timer), 2);
    check("ab_pre_env", int'(a_env), 16);
    abort = 1'b1;
    tick();
    check("ab_phase", int'(a_phase), 7);
    check("ab_env", int'(a_env), 0);
    check("ab_timer", int'(a_timer), 2);
    tick();
    check("ab_refr1", int'(a_phase), 7);
    tick();
    check("ab_refr2", int'(a_phase), 7);
    tick();
    check("ab_idle", int'(a_phase), 1);

    // Trigger and abort together in IDLE, with all-zero durations.
    set_durs(0, 0, 0, 0, 0, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    abort = 1'b0;
    check("zero_phase", int'(a_phase), ZERO_PH[0]);
    for (int i = 1; i < 7; i++) begin
      tick();
      check("zero_phase", int'(a_phase), ZERO_PH[i]);
    end

    // Asynchronous reset in the middle of PLATEAU.
    set_durs(1, 1, 5, 1, 1, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (3) tick();
    check("pre_rst_phase", int'(a_phase), 4);
    #2 rst = 1'b1;
    #1;
    check("arst_phase", int'(a_phase), 1);
    check("arst_env", int'(a_env), 0);
    check("arst_timer", int'(a_timer), 0);
    check("arst_active", int'(a_active), 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    check("post_rst_phase", int'(a_phase), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
